rdm_harq_combine: RTL and testbench
===================================

// Module: rdm_harq_combine
// PURPOSE
//  Downstream consumer of the rate-dematching (RDM) read-out stage. Requests one RDM stream per job and
//  accepts 96-bit beats of 16 signed 6-bit LLRs. Each beat is combined lane-wise with the stored HARQ
//  soft-buffer word using a saturating add, then written back, for Ncb LLRs in total.
//  Sits between the RDM FSM and the HARQ soft-buffer RAM. The RAM is simple dual port with 1-cycle read latency.
// PARAMETERS
//  LANES   16  LLRs per beat
//  LLR_W   6   signed LLR width; data width = LANES*LLR_W = 96
//  ADDR_W  12  HARQ buffer word-address width
// PORTS
//  i_core_clk           in   1       core clock, all logic on rising edge
//  i_rx_rstn            in   1       async active-low global reset
//  i_rx_fsm_rstn        in   1       async active-low FSM reset, same effect as i_rx_rstn
//  i_Combine_start      in   1       1-cycle job start, sampled in IDLE only
//  i_Ncb_Size           in   16      LLRs in this job, 1..16*2^ADDR_W
//  i_First_Tx           in   1       1: write RDM data without combining (ignore stored word)
//  o_RDM_Data_Request   out  1       1-cycle request pulse to the RDM stage
//  i_RDM_Data_Valid     in   1       beat valid
//  i_RDM_Data_Comp      in   1       RDM stream complete
//  i_RDM_Data_Content   in   96      beat; lane k = bits [6k+5:6k]
//  o_Harq_Rd_En         out  1       soft-buffer read enable
//  o_Harq_Rd_Addr       out  ADDR_W  soft-buffer read address
//  i_Harq_Rd_Data       in   96      read data, valid 1 cycle after o_Harq_Rd_En
//  o_Harq_Wr_En         out  1       soft-buffer write enable
//  o_Harq_Wr_Addr       out  ADDR_W  soft-buffer write address
//  o_Harq_Wr_Data       out  96      combined word
//  o_Combine_Busy       out  1       high from leaving IDLE until return to IDLE
//  o_Combine_Done       out  1       1-cycle pulse at job end
//  o_Len_Error          out  1       sticky per job: beat count differs from Nwords
//  o_Sat_Count          out  16      lanes saturated in this job; holds at 16'hFFFF
// BEHAVIOUR
//  Reset (either rstn low, asynchronous):
//   - state IDLE; all outputs 0; word counter and pipeline cleared.
//   - A write in flight is dropped. No Wr_En is asserted during or after reset.
//  Job setup:
//   - Nwords = ceil(Ncb/16) = Ncb[15:4] + (Ncb[3:0]!=0).
//   - Ncb, Nwords and First_Tx are latched on start.
//  States:
//   - IDLE: start -> REQ. Clears o_Len_Error and o_Sat_Count.
//   - REQ: o_RDM_Data_Request=1 for exactly 1 cycle -> RUN.
//   - RUN, per valid beat:
//     - Rd_En=1 and Rd_Addr=wcnt in the same cycle; wcnt++.
//     - After the beat with wcnt==Nwords-1, or when Comp=1 -> FLUSH.
//     - If Comp and a valid beat arrive in the same cycle, the beat is processed first.
//   - FLUSH: wait until the pipeline is empty (at most 2 cycles) -> DONE.
//   - DONE: Done=1 for 1 cycle -> IDLE.
//  Latency:
//   - Beat valid at cycle t -> Wr_En at t+2 with Wr_Addr = that beat's address.
//   - Back-to-back beats are supported at 1 beat/cycle.
//  Combine, per lane:
//   - s = old + new in 7-bit signed arithmetic, clamped to [-32,+31]. Each clamp increments Sat_Count.
//   - First_Tx=1: result = new, and no read is issued.
//  Last partial word (Ncb[3:0]!=0):
//   - Lanes >= Ncb[3:0] keep the old stored value.
//   - When First_Tx=1, those lanes are written as 0.
//  Length checks:
//   - Comp with beats < Nwords: o_Len_Error=1, then FLUSH.
//   - Beats after Nwords (in FLUSH/DONE/IDLE) are ignored: no RAM access, and o_Len_Error=1 if still in the job.
//  Addresses are unique within a job, so there is no RAW hazard. Start while busy is ignored.
//  Reset mid-job: abort immediately; the next job starts clean from wcnt=0.
// TESTING
//  1. First_Tx=1, Ncb=64, 4 beats back-to-back
//     -> Wr addr 0..3 at t+2..t+5 with data = beats; Rd_En never 1; Done 1 cycle after last write.
//  2. First_Tx=0, stored lanes=+20, new lanes=+20, Ncb=32
//     -> all lanes written +31, Sat_Count=32; stored -5 and new +3 -> -2, no count.
//  3. Ncb=20 (Nwords=2), stored=7, new=1, First_Tx=0
//     -> word1 lanes0-3 = 8, lanes4-15 stay 7; Len_Error=0.
//  4. Ncb=64, Comp after 2 beats -> 2 writes, Len_Error=1, Done pulses.
//     Extra 5th beat in a 4-word job -> ignored, Len_Error=1.
//  5. i_rx_fsm_rstn low 1 cycle after 2nd beat -> no further Wr_En, Busy=0.
//     New start -> Request pulse and writes from addr 0.
//  6. Valid with gaps (1 beat every 3 cycles) and start pulsed while busy
//     -> correct addresses and data; no second Request.

Source files
------------

// File: rtl/rdm_harq_combine.sv
// rtl/rdm_harq_combine.sv - RDM beat to HARQ soft-buffer saturating combiner
module rdm_harq_combine #(
    parameter int LANES  = 16,
    parameter int LLR_W  = 6,
    parameter int ADDR_W = 12
) (
    input  logic                      i_core_clk,
    input  logic                      i_rx_rstn,
    input  logic                      i_rx_fsm_rstn,
    input  logic                      i_Combine_start,
    input  logic [15:0]               i_Ncb_Size,
    input  logic                      i_First_Tx,
    output logic                      o_RDM_Data_Request,
    input  logic                      i_RDM_Data_Valid,
    input  logic                      i_RDM_Data_Comp,
    input  logic [LANES*LLR_W-1:0]    i_RDM_Data_Content,
    output logic                      o_Harq_Rd_En,
    output logic [ADDR_W-1:0]         o_Harq_Rd_Addr,
    input  logic [LANES*LLR_W-1:0]    i_Harq_Rd_Data,
    output logic                      o_Harq_Wr_En,
    output logic [ADDR_W-1:0]         o_Harq_Wr_Addr,
    output logic [LANES*LLR_W-1:0]    o_Harq_Wr_Data,
    output logic                      o_Combine_Busy,
    output logic                      o_Combine_Done,
    output logic                      o_Len_Error,
    output logic [15:0]               o_Sat_Count
);

    localparam int DW = LANES * LLR_W;
    localparam int LB = $clog2(LANES);
    localparam int CW = $clog2(LANES + 1);
    localparam logic [LLR_W-1:0] LLR_MAX = {1'b0, {(LLR_W-1){1'b1}}};
    localparam logic [LLR_W-1:0] LLR_MIN = {1'b1, {(LLR_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Either reset line aborts everything immediately.
    logic rst_n;
    assign rst_n = i_rx_rstn & i_rx_fsm_rstn;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wcnt_q;
    logic [ADDR_W-1:0] nw_m1_q;
    logic [LB-1:0]     rem_q;
    logic              first_q;
    logic              len_err_q;
    logic [15:0]       sat_q;

    logic              s1_vld_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [DW-1:0]     s1_data_q;
    logic [LANES-1:0]  s1_mask_q;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DW-1:0]     wr_data_q;

    logic              start_ok;
    logic              beat_ok;
    logic              last_beat;
    logic [ADDR_W-1:0] ncb_words_m1;
    logic [LANES-1:0]  beat_mask;
    logic [DW-1:0]     comb_data;
    logic [CW-1:0]     sat_inc;
    logic [16:0]       sat_sum;

    // Word count minus one; Ncb=0 wraps to the full buffer.
    assign ncb_words_m1 = ADDR_W'(i_Ncb_Size[15:LB]) + ADDR_W'(|i_Ncb_Size[LB-1:0]) - ADDR_W'(1);
    assign start_ok     = (state_q == S_IDLE) && i_Combine_start;
    assign beat_ok      = (state_q == S_RUN) && i_RDM_Data_Valid;
    assign last_beat    = beat_ok && (wcnt_q == nw_m1_q);
    assign sat_sum      = {1'b0, sat_q} + 17'(sat_inc);

    // Lanes beyond the job's LLR count in the final partial word are inactive.
    always_comb begin
        beat_mask = '1;
        for (int k = 0; k < LANES; k++) begin
            if ((wcnt_q == nw_m1_q) && (rem_q != '0) && !(LB'(k) < rem_q)) begin
                beat_mask[k] = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge i_core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a beat arriving with Comp is still counted first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_Combine_start) state_d = S_REQ;
            S_REQ:   state_d = S_RUN;
            S_RUN:   if (last_beat || i_RDM_Data_Comp) state_d = S_FLUSH;
            S_FLUSH: if (!s1_vld_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM-decoded outputs; reads are skipped entirely on a first transmission.
    always_comb begin
        o_RDM_Data_Request = (state_q == S_REQ);
        o_Combine_Busy     = (state_q != S_IDLE);
        o_Combine_Done     = (state_q == S_DONE);
        o_Harq_Rd_En       = beat_ok && !first_q;
        o_Harq_Rd_Addr     = wcnt_q;
    end

    // Job parameters, word counter, length error and saturation counter.
    always_ff @(posedge i_core_clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q    <= '0;
            nw_m1_q   <= '0;
            rem_q     <= '0;
            first_q   <= 1'b0;
            len_err_q <= 1'b0;
            sat_q     <= '0;
        end else if (start_ok) begin
            wcnt_q    <= '0;
            nw_m1_q   <= ncb_words_m1;
            rem_q     <= i_Ncb_Size[LB-1:0];
            first_q   <= i_First_Tx;
            len_err_q <= 1'b0;
            sat_q     <= '0;
        end else begin
            if (beat_ok) begin
                wcnt_q <= wcnt_q + ADDR_W'(1);
            end
            if ((state_q == S_RUN) && i_RDM_Data_Comp && !last_beat) begin
                len_err_q <= 1'b1;
            end
            if (((state_q == S_FLUSH) || (state_q == S_DONE)) && i_RDM_Data_Valid) begin
                len_err_q <= 1'b1;
            end
            if (s1_vld_q) begin
                sat_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
            end
        end
    end

    // Stage 1: hold the beat while the soft-buffer read returns.
    always_ff @(posedge i_core_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_data_q <= '0;
            s1_mask_q <= '0;
        end else begin
            s1_vld_q <= beat_ok;
            if (beat_ok) begin
                s1_addr_q <= wcnt_q;
                s1_data_q <= i_RDM_Data_Content;
                s1_mask_q <= beat_mask;
            end
        end
    end

    // Lane-wise saturating combine of stored and new LLRs.
    always_comb begin
        comb_data = '0;
        sat_inc   = '0;
        for (int k = 0; k < LANES; k++) begin
            logic [LLR_W-1:0] old_l;
            logic [LLR_W-1:0] new_l;
            logic [LLR_W:0]   sum;
            logic [LLR_W-1:0] lane;
            old_l = i_Harq_Rd_Data[k*LLR_W +: LLR_W];
            new_l = s1_data_q[k*LLR_W +: LLR_W];
            sum   = {old_l[LLR_W-1], old_l} + {new_l[LLR_W-1], new_l};
            lane  = '0;
            if (!s1_mask_q[k]) begin
                lane = first_q ? '0 : old_l;
            end else if (first_q) begin
                lane = new_l;
            end else if (sum[LLR_W] != sum[LLR_W-1]) begin
                lane    = sum[LLR_W] ? LLR_MIN : LLR_MAX;
                sat_inc = sat_inc + CW'(1);
            end else begin
                lane = sum[LLR_W-1:0];
            end
            comb_data[k*LLR_W +: LLR_W] = lane;
        end
    end

    // Stage 2: registered write-back, two cycles after the beat.
    always_ff @(posedge i_core_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= s1_vld_q;
            if (s1_vld_q) begin
                wr_addr_q <= s1_addr_q;
                wr_data_q <= comb_data;
            end
        end
    end

    assign o_Harq_Wr_En   = wr_en_q;
    assign o_Harq_Wr_Addr = wr_addr_q;
    assign o_Harq_Wr_Data = wr_data_q;
    assign o_Len_Error    = len_err_q;
    assign o_Sat_Count    = sat_q;

endmodule

// File: tb/tb_rdm_harq_combine.sv
// tb/tb_rdm_harq_combine.sv - self-checking bench for rdm_harq_combine
module tb_rdm_harq_combine;

    logic        clk = 1'b0;
    logic        rstn, fsm_rstn, start, first_tx, valid, comp;
    logic [15:0] ncb;
    logic [95:0] content, rd_data;
    logic        req, rd_en, wr_en, busy, done, len_err;
    logic [11:0] rd_addr, wr_addr;
    logic [95:0] wr_data;
    logic [15:0] sat;

    always #5 clk = ~clk;

    rdm_harq_combine dut (
        .i_core_clk(clk), .i_rx_rstn(rstn), .i_rx_fsm_rstn(fsm_rstn),
        .i_Combine_start(start), .i_Ncb_Size(ncb), .i_First_Tx(first_tx),
        .o_RDM_Data_Request(req), .i_RDM_Data_Valid(valid), .i_RDM_Data_Comp(comp),
        .i_RDM_Data_Content(content), .o_Harq_Rd_En(rd_en), .o_Harq_Rd_Addr(rd_addr),
        .i_Harq_Rd_Data(rd_data), .o_Harq_Wr_En(wr_en), .o_Harq_Wr_Addr(wr_addr),
        .o_Harq_Wr_Data(wr_data), .o_Combine_Busy(busy), .o_Combine_Done(done),
        .o_Len_Error(len_err), .o_Sat_Count(sat)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [95:0] mem [0:4095];
    logic        pl_we = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [95:0] pl_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Soft-buffer RAM: 1-cycle read latency; bench preload shares the write port.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
        if (pl_we) mem[pl_addr] <= pl_data;
    end

    logic [11:0] wl_addr[$];
    logic [95:0] wl_data[$];
    int          wl_cyc[$];
    int          rd_cnt = 0, req_cnt = 0, done_cnt = 0, done_cyc = 0;

    // Event log sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en) begin
            wl_addr.push_back(wr_addr);
            wl_data.push_back(wr_data);
            wl_cyc.push_back(cyc);
        end
        if (rd_en) rd_cnt <= rd_cnt + 1;
        if (req) req_cnt <= req_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    logic [95:0] beats[$];
    logic [95:0] pre[0:63];
    logic [95:0] exp_w[0:63];
    int          exp_sat;

    function automatic logic [95:0] rep(input int v);
        logic [5:0] l;
        l = v[5:0];
        return {16{l}};
    endfunction

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Reference: integer add with clamp to [-32,31]; inactive lanes keep old (or 0 on first tx).
    function automatic logic [95:0] model_word(input logic [95:0] old_w, input logic [95:0] new_w,
                                               input bit first, input int nact, output int nsat);
        logic [95:0]      res;
        logic signed [5:0] ol, nl;
        int o, n, r;
        res  = '0;
        nsat = 0;
        for (int k = 0; k < 16; k++) begin
            ol = old_w[6*k +: 6];
            nl = new_w[6*k +: 6];
            o = ol;
            n = nl;
            if (k >= nact) r = first ? 0 : o;
            else if (first) r = n;
            else begin
                r = o + n;
                if (r > 31) begin r = 31; nsat++; end
                else if (r < -32) begin r = -32; nsat++; end
            end
            res[6*k +: 6] = r[5:0];
        end
        return res;
    endfunction

    task automatic build_expect(input int ncbv, input bit first, input int nb);
        int nw, ns, nact;
        nw = (ncbv + 15) / 16;
        exp_sat = 0;
        for (int j = 0; j < 64; j++) exp_w[j] = pre[j];
        for (int j = 0; j < nb && j < nw; j++) begin
            nact = (j == nw - 1 && ncbv % 16 != 0) ? ncbv % 16 : 16;
            exp_w[j] = model_word(pre[j], beats[j], first, nact, ns);
            exp_sat += ns;
        end
    endtask

    task automatic preload(input int a, input logic [95:0] d);
        pl_we = 1'b1; pl_addr = 12'(a); pl_data = d;
        @(posedge clk) #1;
        pl_we = 1'b0;
    endtask

    task automatic snapshot();
        for (int j = 0; j < 64; j++) pre[j] = mem[j];
    endtask

    task automatic start_job(input int ncbv, input bit first);
        @(posedge clk) #1;
        start = 1'b1; ncb = 16'(ncbv); first_tx = first;
        @(posedge clk) #1;
        start = 1'b0;
        @(posedge clk) #1;
    endtask

    task automatic drive(input bit v, input logic [95:0] d, input bit c);
        valid = v; content = d; comp = c;
        @(posedge clk) #1;
        valid = 1'b0; comp = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int b;
        b = done_cnt;
        for (int i = 0; i < 50; i++) begin
            if (done_cnt != b) break;
            @(posedge clk) #1;
        end
        ok = (done_cnt != b);
    endtask

    task automatic test_reset();
        rstn = 1'b0; fsm_rstn = 1'b1; start = 0; first_tx = 0; valid = 0; comp = 0;
        ncb = '0; content = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if ({req, rd_en, wr_en, busy, done, len_err} !== 6'b0) begin n_errors++;
            $display("FAIL reset_flags: got %b required 000000", {req, rd_en, wr_en, busy, done, len_err}); end
        n_checks++; if (sat !== 16'd0 || wr_addr !== 12'd0 || rd_addr !== 12'd0) begin n_errors++;
            $display("FAIL reset_counts: sat %0d wr_addr %0d rd_addr %0d required 0", sat, wr_addr, rd_addr); end
        n_checks++; if (wr_data !== 96'd0) begin n_errors++;
            $display("FAIL reset_wr_data: got %h required 0", wr_data); end
        rstn = 1'b1;
        for (int j = 0; j < 64; j++) preload(j, '0);
    endtask

    task automatic test_first_tx();
        int wb, rb, t0;
        bit ok;
        beats.delete();
        for (int j = 0; j < 4; j++) begin preload(j, rnd96()); beats.push_back(rnd96()); end
        snapshot();
        wb = wl_addr.size(); rb = rd_cnt;
        start_job(64, 1'b1);
        t0 = cyc;
        for (int j = 0; j < 4; j++) drive(1'b1, beats[j], 1'b0);
        wait_done(ok);
        build_expect(64, 1'b1, 4);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL ftx_done: no Done within bound"); end
        n_checks++; if (wl_addr.size() - wb != 4) begin n_errors++;
            $display("FAIL ftx_wr_count: got %0d required 4", wl_addr.size() - wb); end
        for (int j = 0; j < 4 && wb + j < wl_addr.size(); j++) begin
            n_checks++; if (wl_addr[wb+j] !== 12'(j) || wl_data[wb+j] !== beats[j] || wl_cyc[wb+j] != t0 + j + 2) begin
                n_errors++; $display("FAIL ftx_write%0d: addr %0d cyc %0d data %h required addr %0d cyc %0d data %h",
                    j, wl_addr[wb+j], wl_cyc[wb+j] - t0, wl_data[wb+j], j, j + 2, beats[j]); end
        end
        n_checks++; if (rd_cnt != rb) begin n_errors++; $display("FAIL ftx_no_read: got %0d reads required 0", rd_cnt - rb); end
        n_checks++; if (done_cyc != t0 + 6) begin n_errors++;
            $display("FAIL ftx_done_cycle: got %0d required %0d", done_cyc - t0, 6); end
        n_checks++; if (len_err !== 1'b0 || sat !== 16'd0) begin n_errors++;
            $display("FAIL ftx_status: len_err %b sat %0d required 0 0", len_err, sat); end
        for (int j = 0; j < 8; j++) begin
            n_checks++; if (mem[j] !== exp_w[j]) begin n_errors++;
                $display("FAIL ftx_mem%0d: got %h required %h", j, mem[j], exp_w[j]); end
        end
    endtask

    task automatic test_saturate();
        bit ok;
        for (int pass = 0; pass < 2; pass++) begin
            beats.delete();
            for (int j = 0; j < 2; j++) begin
                preload(j, rep(pass == 0 ? 20 : -5));
                beats.push_back(rep(pass == 0 ? 20 : 3));
            end
            start_job(32, 1'b0);
            for (int j = 0; j < 2; j++) drive(1'b1, beats[j], 1'b0);
            wait_done(ok);
            n_checks++; if (!ok) begin n_errors++; $display("FAIL sat_done%0d: no Done within bound", pass); end
            for (int j = 0; j < 2; j++) begin
                n_checks++; if (mem[j] !== rep(pass == 0 ? 31 : -2)) begin n_errors++;
                    $display("FAIL sat_mem%0d_%0d: got %h required %h", pass, j, mem[j], rep(pass == 0 ? 31 : -2)); end
            end
            n_checks++; if (sat !== 16'(pass == 0 ? 32 : 0)) begin n_errors++;
                $display("FAIL sat_count%0d: got %0d required %0d", pass, sat, pass == 0 ? 32 : 0); end
        end
    endtask

    task automatic test_partial();
        logic [95:0] e;
        bit ok;
        beats.delete();
        for (int j = 0; j < 3; j++) preload(j, rep(7));
        beats.push_back(rep(1)); beats.push_back(rep(1));
        start_job(20, 1'b0);
        for (int j = 0; j < 2; j++) drive(1'b1, beats[j], 1'b0);
        wait_done(ok);
        for (int k = 0; k < 16; k++) e[6*k +: 6] = (k < 4) ? 6'd8 : 6'd7;
        n_checks++; if (mem[0] !== rep(8)) begin n_errors++; $display("FAIL part_word0: got %h required %h", mem[0], rep(8)); end
        n_checks++; if (mem[1] !== e) begin n_errors++; $display("FAIL part_word1: got %h required %h", mem[1], e); end
        n_checks++; if (mem[2] !== rep(7)) begin n_errors++; $display("FAIL part_word2: got %h required %h", mem[2], rep(7)); end
        n_checks++; if (len_err !== 1'b0 || !ok) begin n_errors++;
            $display("FAIL part_status: len_err %b done %b required 0 1", len_err, ok); end
    endtask

    task automatic test_short_comp();
        int wb;
        bit ok;
        beats.delete();
        for (int j = 0; j < 4; j++) begin preload(j, rnd96()); beats.push_back(rnd96()); end
        snapshot();
        wb = wl_addr.size();
        start_job(64, 1'b0);
        drive(1'b1, beats[0], 1'b0);
        drive(1'b1, beats[1], 1'b0);
        drive(1'b0, '0, 1'b1);
        wait_done(ok);
        build_expect(64, 1'b0, 2);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL comp_done: no Done within bound"); end
        n_checks++; if (wl_addr.size() - wb != 2) begin n_errors++;
            $display("FAIL comp_wr_count: got %0d required 2", wl_addr.size() - wb); end
        n_checks++; if (len_err !== 1'b1) begin n_errors++; $display("FAIL comp_len_err: got %b required 1", len_err); end
        n_checks++; if (sat !== 16'(exp_sat)) begin n_errors++; $display("FAIL comp_sat: got %0d required %0d", sat, exp_sat); end
        for (int j = 0; j < 4; j++) begin
            n_checks++; if (mem[j] !== exp_w[j]) begin n_errors++;
                $display("FAIL comp_mem%0d: got %h required %h", j, mem[j], exp_w[j]); end
        end
    endtask

    task automatic test_extra_beat();
        int wb;
        bit ok;
        beats.delete();
        for (int j = 0; j < 5; j++) begin preload(j, rnd96()); beats.push_back(rnd96()); end
        snapshot();
        wb = wl_addr.size();
        start_job(64, 1'b1);
        for (int j = 0; j < 5; j++) drive(1'b1, beats[j], 1'b0);
        wait_done(ok);
        build_expect(64, 1'b1, 5);
        n_checks++; if (wl_addr.size() - wb != 4) begin n_errors++;
            $display("FAIL extra_wr_count: got %0d required 4", wl_addr.size() - wb); end
        n_checks++; if (len_err !== 1'b1 || !ok) begin n_errors++;
            $display("FAIL extra_status: len_err %b done %b required 1 1", len_err, ok); end
        n_checks++; if (mem[4] !== exp_w[4] || mem[3] !== exp_w[3]) begin n_errors++;
            $display("FAIL extra_mem: word4 %h required %h", mem[4], exp_w[4]); end
    endtask

    task automatic test_fsm_reset();
        int wb, rqb;
        bit ok;
        beats.delete();
        for (int j = 0; j < 4; j++) beats.push_back(rnd96());
        start_job(64, 1'b1);
        drive(1'b1, beats[0], 1'b0);
        drive(1'b1, beats[1], 1'b0);
        wb = wl_addr.size();
        fsm_rstn = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || wr_en !== 1'b0) begin n_errors++;
            $display("FAIL rst_abort: busy %b wr_en %b required 0 0", busy, wr_en); end
        @(posedge clk) #1;
        fsm_rstn = 1'b1;
        repeat (4) @(posedge clk) #1;
        n_checks++; if (wl_addr.size() != wb || busy !== 1'b0) begin n_errors++;
            $display("FAIL rst_no_write: writes %0d busy %b required 0 0", wl_addr.size() - wb, busy); end
        beats.delete();
        for (int j = 0; j < 2; j++) beats.push_back(rnd96());
        rqb = req_cnt; wb = wl_addr.size();
        start_job(32, 1'b1);
        for (int j = 0; j < 2; j++) drive(1'b1, beats[j], 1'b0);
        wait_done(ok);
        n_checks++; if (req_cnt - rqb != 1 || !ok) begin n_errors++;
            $display("FAIL rst_restart: requests %0d done %b required 1 1", req_cnt - rqb, ok); end
        n_checks++; if (wl_addr.size() - wb != 2 || wl_addr[wb] !== 12'd0 || wl_data[wb] !== beats[0]) begin n_errors++;
            $display("FAIL rst_restart_write: count %0d first addr %0d required 2 0", wl_addr.size() - wb, wl_addr[wb]); end
    endtask

    task automatic test_gaps_busy();
        int wb, rqb;
        bit ok;
        beats.delete();
        for (int j = 0; j < 3; j++) begin preload(j, rnd96()); beats.push_back(rnd96()); end
        snapshot();
        wb = wl_addr.size(); rqb = req_cnt;
        start_job(48, 1'b0);
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, beats[j], 1'b0);
            if (j < 2) begin
                start = (j == 0);
                @(posedge clk) #1;
                start = 1'b0;
                @(posedge clk) #1;
            end
        end
        wait_done(ok);
        build_expect(48, 1'b0, 3);
        n_checks++; if (req_cnt - rqb != 1 || !ok) begin n_errors++;
            $display("FAIL gap_requests: got %0d done %b required 1 1", req_cnt - rqb, ok); end
        n_checks++; if (wl_addr.size() - wb != 3) begin n_errors++;
            $display("FAIL gap_wr_count: got %0d required 3", wl_addr.size() - wb); end
        for (int j = 0; j < 3 && wb + j < wl_addr.size(); j++) begin
            n_checks++; if (wl_addr[wb+j] !== 12'(j) || wl_data[wb+j] !== exp_w[j]) begin n_errors++;
                $display("FAIL gap_write%0d: addr %0d data %h required addr %0d data %h",
                    j, wl_addr[wb+j], wl_data[wb+j], j, exp_w[j]); end
        end
        n_checks++; if (sat !== 16'(exp_sat)) begin n_errors++; $display("FAIL gap_sat: got %0d required %0d", sat, exp_sat); end
    endtask

    task automatic test_random();
        int ncbv, nw, wb;
        bit first, ok;
        for (int r = 0; r < 6; r++) begin
            ncbv  = $urandom_range(1, 160);
            nw    = (ncbv + 15) / 16;
            first = 1'($urandom_range(0, 1));
            beats.delete();
            for (int j = 0; j < nw; j++) begin preload(j, rnd96()); beats.push_back(rnd96()); end
            snapshot();
            wb = wl_addr.size();
            start_job(ncbv, first);
            for (int j = 0; j < nw; j++) begin
                drive(1'b1, beats[j], 1'b0);
                if ($urandom_range(0, 1) == 1) @(posedge clk) #1;
            end
            wait_done(ok);
            build_expect(ncbv, first, nw);
            n_checks++; if (!ok || len_err !== 1'b0 || wl_addr.size() - wb != nw) begin n_errors++;
                $display("FAIL rnd%0d_status: done %b len_err %b writes %0d required 1 0 %0d",
                    r, ok, len_err, wl_addr.size() - wb, nw); end
            n_checks++; if (sat !== 16'(exp_sat)) begin n_errors++;
                $display("FAIL rnd%0d_sat: got %0d required %0d", r, sat, exp_sat); end
            for (int j = 0; j < 12; j++) begin
                n_checks++; if (mem[j] !== exp_w[j]) begin n_errors++;
                    $display("FAIL rnd%0d_mem%0d: got %h required %h", r, j, mem[j], exp_w[j]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_tx();
        test_saturate();
        test_partial();
        test_short_comp();
        test_extra_beat();
        test_fsm_reset();
        test_gaps_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
